da_divider: RTL

Sequential unsigned divider: the inverse operation of the DA multiplier, used on the same datapath to recover one operand from a product. Restoring shift-subtract algorithm, one quotient bit per clock. Start/done handshake; results are registered and held until the next operation completes. Same operand naming and widths as the multiplier, so the two blocks can be swapped in the same test harness.

---
 rtl/da_divider.sv | 85 ++++++++
 1 files changed

// File: rtl/da_divider.sv
// da_divider: restoring shift-subtract unsigned divider, one quotient bit per clock.
module da_divider #(
  parameter int ASIZE = 8,
  parameter int BSIZE = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ASIZE-1:0] adata,
  input  logic [BSIZE-1:0] bdata,
  output logic             busy,
  output logic             done,
  output logic [ASIZE-1:0] qdata,
  output logic [BSIZE-1:0] rdata,
  output logic             div_zero
);
  localparam int CW = $clog2(ASIZE + 1);
  if (BSIZE > ASIZE) begin : g_bad_size
    $error("da_divider: BSIZE must not exceed ASIZE");
  end
  typedef enum logic {IDLE, CALC} state_t;
  state_t           state;
  logic [ASIZE-1:0] a_sh;
  logic [BSIZE-1:0] b_r;
  logic [BSIZE:0]   r_acc;
  logic [ASIZE-1:0] q_sh;
  logic [CW-1:0]    cnt;
  logic [BSIZE+1:0] t;
  logic             ge;
  logic [BSIZE:0]   r_nx;
  logic [ASIZE-1:0] q_nx;
  // r_acc[BSIZE] is always 0 after a step; carrying it keeps the compare exact
  always_comb begin
    t    = {r_acc, a_sh[ASIZE-1]};
    ge   = t >= {2'b00, b_r};
    r_nx = (BSIZE+1)'(ge ? t - {2'b00, b_r} : t);
    q_nx = {q_sh[ASIZE-2:0], ge};
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_r      <= '0;
      r_acc    <= '0;
      q_sh     <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      qdata    <= '0;
      rdata    <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && |bdata) begin
          a_sh  <= adata;
          b_r   <= bdata;
          r_acc <= '0;
          q_sh  <= '0;
          cnt   <= CW'(ASIZE);
          busy  <= 1'b1;
          state <= CALC;
        end else if (start) begin
          qdata    <= '1;
          rdata    <= adata[BSIZE-1:0];
          div_zero <= 1'b1;
          done     <= 1'b1;
        end
      end else begin
        a_sh  <= a_sh << 1;
        r_acc <= r_nx;
        q_sh  <= q_nx;
        cnt   <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          qdata    <= q_nx;
          rdata    <= r_nx[BSIZE-1:0];
          div_zero <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      end
    end
  end
endmodule
